// File: rtl/add3_pkg.sv
// Shared definitions for the three-operand adder: op encodings (also used by
// microcode decode), parameter legality checks and the pipeline split point.
package add3_pkg;

  localparam logic [1:0] OP_ADD01 = 2'b00;  // I0 + I1 + CI
  localparam logic [1:0] OP_SUB01 = 2'b01;  // I0 + ~I1 + CI (CI=1 -> no borrow)
  localparam logic [1:0] OP_ADD02 = 2'b10;  // I0 + I2 + CI
  localparam logic [1:0] OP_ADD12 = 2'b11;  // I1 + I2 + CI

  function automatic bit latency_ok(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

  function automatic bit width_ok(input int w);
    return (w >= 4) && (w <= 32) && ((w % 4) == 0);
  endfunction

  // Bit position where the two-stage carry chain is cut: half the width,
  // rounded down to a whole 4-bit slice (0 for WIDTH=4, i.e. no low half).
  function automatic int split_point(input int w);
    return ((w / 2) / 4) * 4;
  endfunction

endpackage

// File: rtl/add4_slice.sv
// One 4-bit carry-chain slice: per-bit propagate/generate feeding a ripple
// carry, shaped to map onto four LUT6_2 cells and one CARRY4.
module add4_slice (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       ci_i,
  output logic [3:0] s_o,
  output logic       co_o
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  assign p    = a_i ^ b_i;
  assign g    = a_i & b_i;
  assign c[0] = ci_i;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign c[i+1] = g[i] | (p[i] & c[i]);
  end

  assign s_o  = p ^ c[3:0];
  assign co_o = c[4];

endmodule

// File: rtl/add3_pipe.sv
// Pipelined three-operand adder/subtractor with carry, overflow, zero and
// negative flags. LATENCY=1 registers the whole sum; LATENCY=2 cuts the carry
// chain at split_point(WIDTH) and finishes the high half in a second stage.
module add3_pipe
  import add3_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             RDY,
  input  logic             in_valid,
  input  logic             CI,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic [WIDTH-1:0] I2,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] O,
  output logic             CO,
  output logic             V,
  output logic             Z,
  output logic             N,
  output logic             out_valid
);

  localparam int NS = WIDTH / 4;

  if (!latency_ok(LATENCY) || !width_ok(WIDTH)) begin : g_bad_param
    $error("add3_pipe: illegal WIDTH/LATENCY parameter");
  end

  // Operand routing; b_s is the raw second addend, inverted later for SUB.
  logic [WIDTH-1:0] a_s;
  logic [WIDTH-1:0] b_s;
  logic             inv_s;

  // Select the two addends from the three operands by op.
  always_comb begin
    a_s   = I0;
    b_s   = I1;
    inv_s = 1'b0;
    case (op)
      OP_ADD01: ;
      OP_SUB01: inv_s = 1'b1;
      OP_ADD02: b_s   = I2;
      default: begin
        a_s = I1;
        b_s = I2;
      end
    endcase
  end

  // Next values of the output stage, produced by the latency-specific datapath.
  logic [WIDTH-1:0] o_d;
  logic             co_d;
  logic             a_msb_d;
  logic             b_msb_d;
  logic             z_d;
  logic             vld_d;
  logic             v_d;

  assign v_d = (a_msb_d == b_msb_d) && (o_d[WIDTH-1] != a_msb_d);

  if (LATENCY == 1) begin : g_lat1
    // ---- stage 0 -> output: full carry chain in one cycle
    logic [WIDTH-1:0] b_e;
    logic [NS:0]      c;

    assign b_e  = inv_s ? ~b_s : b_s;
    assign c[0] = CI;

    for (genvar k = 0; k < NS; k++) begin : g_slice
      add4_slice u_slice (
        .a_i  (a_s[4*k +: 4]),
        .b_i  (b_e[4*k +: 4]),
        .ci_i (c[k]),
        .s_o  (o_d[4*k +: 4]),
        .co_o (c[k+1])
      );
    end

    assign co_d    = c[NS];
    assign a_msb_d = a_s[WIDTH-1];
    assign b_msb_d = b_e[WIDTH-1];
    assign z_d     = (o_d == '0);
    assign vld_d   = in_valid;
  end else begin : g_lat2
    localparam int SPLIT = split_point(WIDTH);
    localparam int NLO   = SPLIT / 4;
    localparam int NHI   = NS - NLO;

    logic                   c_lo;
    logic                   z_lo;
    logic [WIDTH-1:SPLIT]   a_hi_p1_q;
    logic [WIDTH-1:SPLIT]   b_hi_p1_q;
    logic [1:0]             op_p1_q;
    logic                   c_p1_q;
    logic                   zlo_p1_q;
    logic                   vld_p1_q;

    // ---- stage 0 -> stage 1: low half of the carry chain
    if (SPLIT > 0) begin : g_lo
      logic [SPLIT-1:0] b_lo_e;
      logic [SPLIT-1:0] sum_lo;
      logic [SPLIT-1:0] sum_lo_p1_q;
      logic [NLO:0]     cl;

      assign b_lo_e = inv_s ? ~b_s[SPLIT-1:0] : b_s[SPLIT-1:0];
      assign cl[0]  = CI;

      for (genvar k = 0; k < NLO; k++) begin : g_slice
        add4_slice u_slice (
          .a_i  (a_s[4*k +: 4]),
          .b_i  (b_lo_e[4*k +: 4]),
          .ci_i (cl[k]),
          .s_o  (sum_lo[4*k +: 4]),
          .co_o (cl[k+1])
        );
      end

      assign c_lo = cl[NLO];
      assign z_lo = (sum_lo == '0);

      // Low-half sum register, advanced with the rest of stage 1.
      always_ff @(posedge clk or posedge RST) begin
        if (RST)      sum_lo_p1_q <= '0;
        else if (RDY) sum_lo_p1_q <= sum_lo;
      end

      assign o_d[SPLIT-1:0] = sum_lo_p1_q;
    end else begin : g_nolo
      assign c_lo = CI;
      assign z_lo = 1'b1;
    end

    // Stage-1 register: high operands (raw), op, low carry, low zero, valid.
    always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
        a_hi_p1_q <= '0;
        b_hi_p1_q <= '0;
        op_p1_q   <= OP_ADD01;
        c_p1_q    <= 1'b0;
        zlo_p1_q  <= 1'b0;
        vld_p1_q  <= 1'b0;
      end else if (RDY) begin
        a_hi_p1_q <= a_s[WIDTH-1:SPLIT];
        b_hi_p1_q <= b_s[WIDTH-1:SPLIT];
        op_p1_q   <= op;
        c_p1_q    <= c_lo;
        zlo_p1_q  <= z_lo;
        vld_p1_q  <= in_valid;
      end
    end

    // ---- stage 1 -> output: high half from the registered carry
    logic [WIDTH-1:SPLIT] b_hi_e;
    logic [NHI:0]         ch;

    assign b_hi_e = (op_p1_q == OP_SUB01) ? ~b_hi_p1_q : b_hi_p1_q;
    assign ch[0]  = c_p1_q;

    for (genvar k = 0; k < NHI; k++) begin : g_slice_hi
      add4_slice u_slice (
        .a_i  (a_hi_p1_q[SPLIT+4*k +: 4]),
        .b_i  (b_hi_e[SPLIT+4*k +: 4]),
        .ci_i (ch[k]),
        .s_o  (o_d[SPLIT+4*k +: 4]),
        .co_o (ch[k+1])
      );
    end

    assign co_d    = ch[NHI];
    assign a_msb_d = a_hi_p1_q[WIDTH-1];
    assign b_msb_d = b_hi_e[WIDTH-1];
    assign z_d     = zlo_p1_q && (o_d[WIDTH-1:SPLIT] == '0);
    assign vld_d   = vld_p1_q;
  end

  logic [WIDTH-1:0] o_q;
  logic             co_q;
  logic             v_q;
  logic             z_q;
  logic             n_q;
  logic             vld_q;

  // Output register: result and flags, held while RDY is low.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      o_q   <= '0;
      co_q  <= 1'b0;
      v_q   <= 1'b0;
      z_q   <= 1'b1;
      n_q   <= 1'b0;
      vld_q <= 1'b0;
    end else if (RDY) begin
      o_q   <= o_d;
      co_q  <= co_d;
      v_q   <= v_d;
      z_q   <= z_d;
      n_q   <= o_d[WIDTH-1];
      vld_q <= vld_d;
    end
  end

  assign O         = o_q;
  assign CO        = co_q;
  assign V         = v_q;
  assign Z         = z_q;
  assign N         = n_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_add3_pipe.sv
// Directed and swept checks of add3_pipe across several WIDTH/LATENCY builds.
module tb_add3_pipe;

  logic        clk = 1'b0;
  logic        RST;
  logic        RDY;
  logic        in_valid;
  logic        CI;
  logic [31:0] i0, i1, i2;
  logic [1:0]  op;

  logic [7:0]  o8;   logic co8,  v8,  z8,  n8,  vld8;
  logic [15:0] o16;  logic co16, v16, z16, n16, vld16;
  logic [3:0]  o4;   logic co4,  v4,  z4,  n4,  vld4;
  logic [31:0] o32;  logic co32, v32, z32, n32, vld32;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  add3_pipe #(.WIDTH(8), .LATENCY(1)) u8 (
    .clk(clk), .RST(RST), .RDY(RDY), .in_valid(in_valid), .CI(CI),
    .I0(i0[7:0]), .I1(i1[7:0]), .I2(i2[7:0]), .op(op),
    .O(o8), .CO(co8), .V(v8), .Z(z8), .N(n8), .out_valid(vld8));

  add3_pipe #(.WIDTH(16), .LATENCY(2)) u16 (
    .clk(clk), .RST(RST), .RDY(RDY), .in_valid(in_valid), .CI(CI),
    .I0(i0[15:0]), .I1(i1[15:0]), .I2(i2[15:0]), .op(op),
    .O(o16), .CO(co16), .V(v16), .Z(z16), .N(n16), .out_valid(vld16));

  add3_pipe #(.WIDTH(4), .LATENCY(2)) u4 (
    .clk(clk), .RST(RST), .RDY(RDY), .in_valid(in_valid), .CI(CI),
    .I0(i0[3:0]), .I1(i1[3:0]), .I2(i2[3:0]), .op(op),
    .O(o4), .CO(co4), .V(v4), .Z(z4), .N(n4), .out_valid(vld4));

  add3_pipe #(.WIDTH(32), .LATENCY(1)) u32 (
    .clk(clk), .RST(RST), .RDY(RDY), .in_valid(in_valid), .CI(CI),
    .I0(i0), .I1(i1), .I2(i2), .op(op),
    .O(o32), .CO(co32), .V(v32), .Z(z32), .N(n32), .out_valid(vld32));

  // Packed observation: {valid, N, Z, V, CO, O zero-extended to 32 bits}.
  function automatic logic [36:0] obs8();
    return {vld8, n8, z8, v8, co8, 24'd0, o8};
  endfunction
  function automatic logic [36:0] obs16();
    return {vld16, n16, z16, v16, co16, 16'd0, o16};
  endfunction
  function automatic logic [36:0] obs4();
    return {vld4, n4, z4, v4, co4, 28'd0, o4};
  endfunction
  function automatic logic [36:0] obs32();
    return {vld32, n32, z32, v32, co32, o32};
  endfunction

  // Behavioural (WIDTH+1)-bit sum model, same packing as obsN with valid=1.
  function automatic logic [36:0] model(input int w, input logic [1:0] opv,
                                        input logic [31:0] x0, input logic [31:0] x1,
                                        input logic [31:0] x2, input logic ci);
    logic [31:0] mask, a, b, o;
    logic [32:0] s;
    logic        co, v, an, bn, on;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    case (opv)
      2'd0:    begin a = x0; b = x1;  end
      2'd1:    begin a = x0; b = ~x1; end
      2'd2:    begin a = x0; b = x2;  end
      default: begin a = x1; b = x2;  end
    endcase
    a  = a & mask;
    b  = b & mask;
    s  = {1'b0, a} + {1'b0, b} + {32'd0, ci};
    o  = s[31:0] & mask;
    co = s[w];
    an = a[w-1];
    bn = b[w-1];
    on = o[w-1];
    v  = (an == bn) && (on != an);
    return {1'b1, on, (o == 32'd0), v, co, o};
  endfunction

  task automatic chk(input string tag, input logic [36:0] got, input logic [36:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] opv, input logic [31:0] x0, input logic [31:0] x1,
                       input logic [31:0] x2, input logic ci);
    op = opv; i0 = x0; i1 = x1; i2 = x2; CI = ci;
  endtask

  localparam logic [36:0] RST_STATE = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0};

  initial begin
    RST = 1'b1; RDY = 1'b0; in_valid = 1'b0;
    drive(2'b00, 32'd0, 32'd0, 32'd0, 1'b0);
    #2;
    chk("reset_w8",  obs8(),  RST_STATE);
    chk("reset_w16", obs16(), RST_STATE);
    chk("reset_w4",  obs4(),  RST_STATE);
    chk("reset_w32", obs32(), RST_STATE);

    // First edge after release accepts input: FF + 01 wraps to 00 with carry.
    #1;
    RST = 1'b0; RDY = 1'b1; in_valid = 1'b1;
    drive(2'b00, 32'h0000_00FF, 32'h0000_0001, 32'd0, 1'b0);
    tick();
    chk("w8_add_wrap", obs8(), {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h00});

    // 80 - 01 with no borrow: 7F, signed overflow.
    drive(2'b01, 32'h0000_0080, 32'h0000_0001, 32'd0, 1'b1);
    tick();
    chk("w8_sub_ovf", obs8(), {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h7F});

    // Carry across the stage split of the 16-bit two-stage build, back-to-back.
    drive(2'b10, 32'h0000_00FF, 32'd0, 32'h0000_0001, 1'b0);
    tick();
    drive(2'b10, 32'h0000_1234, 32'd0, 32'h0000_1111, 1'b0);
    tick();
    chk("w16_split_carry", obs16(), {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0100});
    in_valid = 1'b0;
    tick();
    chk("w16_back2back", obs16(), {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h2345});
    tick();
    chk("w16_drain_vld", {vld16, 36'd0}, 37'd0);

    // Stall with two results in flight.
    in_valid = 1'b1;
    drive(2'b00, 32'h0000_7FFF, 32'h0000_0001, 32'd0, 1'b0);
    tick();
    drive(2'b11, 32'd0, 32'h0000_FFFF, 32'h0000_0001, 1'b0);
    tick();
    chk("w16_stall_A", obs16(), {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h8000});
    RDY = 1'b0;
    drive(2'b00, 32'h0000_5555, 32'h0000_1111, 32'd0, 1'b0);
    for (int s = 0; s < 3; s++) begin
      tick();
      chk($sformatf("w16_stall_hold%0d", s), obs16(),
          {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h8000});
    end
    RDY = 1'b1; in_valid = 1'b0;
    tick();
    chk("w16_stall_B", obs16(), {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000});
    tick();
    chk("w16_stall_end", {vld16, 36'd0}, 37'd0);

    // Reset between stage 1 and stage 2 drops the operation.
    in_valid = 1'b1;
    drive(2'b00, 32'h0000_0001, 32'h0000_0002, 32'd0, 1'b0);
    tick();
    RST = 1'b1;
    #1;
    chk("w16_midrst", obs16(), RST_STATE);
    chk("w8_midrst",  obs8(),  RST_STATE);
    #1;
    RST = 1'b0;
    drive(2'b00, 32'h0000_0010, 32'h0000_0020, 32'd0, 1'b1);
    tick();
    chk("w16_dropped_vld", {vld16, 36'd0}, 37'd0);
    chk("w8_after_rst", obs8(), {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h31});
    in_valid = 1'b0;
    tick();
    chk("w16_after_rst", obs16(), {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0031});

    // Sweep: wrap corners first, then random; inputs held two edges so both
    // latencies present the same result.
    in_valid = 1'b1;
    for (int n = 0; n < 40; n++) begin
      case (n)
        0:       drive(2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 32'd0, 1'b0);
        1:       drive(2'b01, 32'h0000_0000, 32'h0000_0001, 32'd0, 1'b1);
        2:       drive(2'b11, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        3:       drive(2'b10, 32'h7FFF_FFFF, 32'd0, 32'h7FFF_FFFF, 1'b1);
        default: drive(2'($urandom_range(3)), $urandom, $urandom, $urandom,
                       1'($urandom_range(1)));
      endcase
      tick();
      tick();
      chk($sformatf("sweep%0d_w8", n),  obs8(),  model(8,  op, i0, i1, i2, CI));
      chk($sformatf("sweep%0d_w16", n), obs16(), model(16, op, i0, i1, i2, CI));
      chk($sformatf("sweep%0d_w4", n),  obs4(),  model(4,  op, i0, i1, i2, CI));
      chk($sformatf("sweep%0d_w32", n), obs32(), model(32, op, i0, i1, i2, CI));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/add3_pipe.md
ADD3_PIPE -- requirements
Module: add3_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand/result width; multiple of 4, range 4..32.
REQ-002 SHALL have parameter LATENCY, default 1: pipeline depth; legal values 1 or 2.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port RST, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port RDY, input, 1: global advance enable; pipeline holds when low.
REQ-006 SHALL have port in_valid, input, 1: operands and op valid this cycle.
REQ-007 SHALL have port CI, input, 1: carry in.
REQ-008 SHALL have ports I0, I1 and I2, input, WIDTH each: operands.
REQ-009 SHALL have port op, input, 2: operation select.
REQ-010 SHALL have port O, output, WIDTH: registered sum.
REQ-011 SHALL have port CO, output, 1: registered carry out of the MSB.
REQ-012 SHALL have port V, output, 1: registered signed overflow.
REQ-013 SHALL have port Z, output, 1: registered flag, O == 0.
REQ-014 SHALL have port N, output, 1: registered copy of O[WIDTH-1].
REQ-015 SHALL have port out_valid, output, 1: O and all flags are valid.

Function
REQ-016 SHALL compute, by op: 00 -> I0+I1+CI; 01 -> I0+~I1+CI (subtract, CI=1 means no borrow); 10 -> I0+I2+CI; 11 -> I1+I2+CI.
REQ-017 SHALL discard bits beyond WIDTH in O; CO SHALL be bit WIDTH of the full (WIDTH+1)-bit sum.
REQ-018 SHALL set V = (A[MSB]==B[MSB]) && (O[MSB]!=A[MSB]), where A and B are the two effective addends after any inversion.
REQ-019 SHALL, with LATENCY=1, register O, flags and out_valid on the first RDY=1 edge after input.
REQ-020 SHALL, with LATENCY=2, split the carry chain at WIDTH/2 (rounded down to a multiple of 4).
REQ-021 SHALL, with LATENCY=2, register in stage 1 the low sum, the low-half carry, the high-half operands, op and the low-half zero term.
REQ-022 SHALL, with LATENCY=2, complete the high half in stage 2 from the registered carry.
REQ-023 SHALL advance every pipeline register only when RDY=1; with RDY=0 all registers, outputs and out_valid SHALL hold.
REQ-024 SHALL make out_valid follow in_valid delayed by exactly LATENCY RDY=1 edges.
REQ-025 SHALL leave the data registers free to load while in_valid=0 (don't-care); out_valid=0 then marks them invalid.
REQ-026 SHALL accept back-to-back in_valid=1 every RDY cycle, giving throughput of one result per cycle.
REQ-027 SHALL make results in flight when RDY drops resume unchanged when RDY returns, with none lost or duplicated.
REQ-028 SHALL produce correct results for all WIDTH values, including wrap-around at all-ones + 1 and at 0 - 1.

Reset
REQ-029 SHALL, while RST=1, asynchronously clear O, CO, V, N, out_valid and all stage registers to 0, and set Z to 1 (consistent with O=0).
REQ-030 SHALL drop any operation in flight when RST asserts mid-pipeline; no out_valid pulse SHALL occur for it after release.
REQ-031 SHALL accept in_valid on the first clk edge after RST deasserts.

Structure
REQ-032 SHALL take the op encodings (OP_ADD01, OP_SUB01, OP_ADD02, OP_ADD12) from a shared package, add3_pkg, also used by microcode decode.
REQ-033 SHALL place the LATENCY legality check and the split-point function in add3_pkg.
REQ-034 SHALL build each 4-bit slice in one sub-module, add4_slice (4 LUT6_2 propagate/generate cells plus one CARRY4), instantiated WIDTH/4 times in a chain.
REQ-035 SHALL hold the valid pipeline, flag logic and stage registers in add3_pipe itself.

Verification
REQ-036 SHALL cover: WIDTH=8, LATENCY=1, op=00, I0=8'hFF, I1=8'h01, CI=0 -> next edge O=8'h00, CO=1, Z=1, V=0, N=0, out_valid=1.
REQ-037 SHALL cover: WIDTH=8, op=01, I0=8'h80, I1=8'h01, CI=1 -> O=8'h7F, CO=1, V=1, N=0.
REQ-038 SHALL cover: WIDTH=16, LATENCY=2, op=10, I0=16'h00FF, I2=16'h0001, CI=0 -> after 2 edges O=16'h0100 (carry crosses stage split), CO=0; back-to-back second input appears one cycle later.
REQ-039 SHALL cover: LATENCY=2, RDY=0 for 3 cycles with two results in flight -> O and out_valid frozen; after RDY=1 the results emerge in order on consecutive cycles.
REQ-040 SHALL cover: RST pulsed between stage 1 and stage 2 -> immediately O=0, Z=1, out_valid=0; no out_valid pulse for the dropped operation.
REQ-041 SHALL cover: random sweep, all ops and WIDTH in {4,8,16,32} -> compare against a behavioural (WIDTH+1)-bit sum model.
